// File: rtl/dbg_pkg.sv
// rtl/dbg_pkg.sv - shared FSM encoding, ASCII constants and hex digit helper for the hexdump scheduler
package dbg_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TAG    = 3'd1,
    COLON  = 3'd2,
    DIGITS = 3'd3,
    EOL    = 3'd4
  } dbg_state_t;

  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_A_UC  = 8'h41;
  localparam logic [7:0] ASCII_A_LC  = 8'h61;

  function automatic logic [7:0] hex2ascii(input logic [3:0] nibble, input logic lowercase);
    if (nibble < 4'd10) begin
      return ASCII_ZERO + {4'h0, nibble};
    end else if (lowercase) begin
      return ASCII_A_LC + {4'h0, nibble} - 8'd10;
    end else begin
      return ASCII_A_UC + {4'h0, nibble} - 8'd10;
    end
  endfunction

endpackage

// File: rtl/dbg_nibble_shift.sv
// rtl/dbg_nibble_shift.sv - 32-bit capture register that walks the word out MSB nibble first
module dbg_nibble_shift (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        load,
  input  logic        shift,
  input  logic [31:0] din,
  output logic [3:0]  nibble,
  output logic [3:0]  next_nibble
);

  logic [31:0] sr;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {sr[27:0], 4'h0};
    end
  end

  // next_nibble lets the scheduler register the following digit on the same edge it shifts
  assign nibble      = sr[31:28];
  assign next_nibble = sr[27:24];

endmodule

// File: rtl/dbg_hexdump_sched.sv
// rtl/dbg_hexdump_sched.sv - round-robin grant of debug words, streamed as "T:HHHHHHHH\n" records
module dbg_hexdump_sched
  import dbg_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter bit LOWERCASE = 1'b0
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   word,
  output logic [NREQ-1:0]      ack,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW-1:0] PTR_RST = IW'(NREQ - 1);

  dbg_state_t    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] win;
  logic [IW-1:0] cand;
  logic [2:0]    dcnt;
  logic [31:0]   win_word;
  logic [3:0]    nib;
  logic [3:0]    nib_next;
  logic          grant;
  logic          xfer;

  // Scanning from the farthest offset down leaves the nearest requester after ptr as winner.
  always_comb begin
    win  = ptr;
    cand = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (req[cand]) begin
        win = cand;
      end
    end
  end

  always_comb begin
    win_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IW'(i)) begin
        win_word = word[32*i +: 32];
      end
    end
  end

  assign grant = (state == IDLE) && (|req);
  assign xfer  = tx_valid && tx_ready;

  dbg_nibble_shift u_shift (
    .clk         (clk),
    .n_rst       (n_rst),
    .load        (grant),
    .shift       ((state == DIGITS) && xfer),
    .din         (win_word),
    .nibble      (nib),
    .next_nibble (nib_next)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      ptr      <= PTR_RST;
      ack      <= '0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      dcnt     <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (grant) begin
            state    <= TAG;
            ptr      <= win;
            ack      <= NREQ'(1) << win;
            tx_data  <= hex2ascii(4'(win), LOWERCASE);
            tx_valid <= 1'b1;
            busy     <= 1'b1;
            dcnt     <= '0;
          end
        end
        TAG: begin
          if (xfer) begin
            state   <= COLON;
            tx_data <= ASCII_COLON;
          end
        end
        COLON: begin
          if (xfer) begin
            state   <= DIGITS;
            tx_data <= hex2ascii(nib, LOWERCASE);
          end
        end
        DIGITS: begin
          if (xfer) begin
            dcnt <= dcnt + 3'd1;
            if (dcnt == 3'd7) begin
              state   <= EOL;
              tx_data <= ASCII_LF;
            end else begin
              tx_data <= hex2ascii(nib_next, LOWERCASE);
            end
          end
        end
        EOL: begin
          if (xfer) begin
            state    <= IDLE;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          tx_valid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dbg_hexdump_sched.md
# dbg_hexdump_sched

Round-robin scheduler for debug word dumps. Up to 16 requesters each offer a 32-bit word. The block grants one requester at a time and captures its word. It then streams a fixed 11-character ASCII record to a byte sink over a valid/ready handshake: requester tag, ':', 8 hex digits MSB-first, '\n'. The block sits between the core's debug taps (PC, instruction, register probes) and the debug UART transmitter, so several taps share one serial output.

## Interface
- NREQ, 4, number of requesters, 1..16
- LOWERCASE, 0, 1 selects 'a'-'f' for hex digits 10-15, 0 selects 'A'-'F'
- clk  in  1  system clock, all state on rising edge
- n_rst  in  1  reset, asynchronous assert, active-low; one clock, reset is asynchronous and active-low
- req  in  NREQ  per-requester level request; word must be stable while req=1
- word  in  32*NREQ  packed words, requester i at [32*i+31:32*i]
- ack  out  NREQ  one-cycle pulse, one-hot, the word of the granted requester was captured
- tx_data  out  8  ASCII character to sink
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  sink accepts tx_data on this edge
- busy  out  1  a record is in progress (state != IDLE)

## Operation
- Reset values: ack=0, tx_data=8'h00, tx_valid=0, busy=0, state=IDLE. The round-robin pointer resets to NREQ-1, so requester 0 wins first.
- States and transitions:
  - IDLE: if any req bit is set, grant and go to TAG.
  - TAG: go to COLON on transfer.
  - COLON: go to DIGITS on transfer.
  - DIGITS: go to EOL after the 8th digit transfer.
  - EOL: go to IDLE on transfer.
- Transfer means tx_valid && tx_ready at a rising edge.
- Arbitration, round-robin:
  - The search starts at pointer+1 modulo NREQ. The first set req bit wins.
  - The pointer updates to the winner at the grant edge.
  - req is sampled only in IDLE. Requests raised while busy wait.
  - A requester may drop req before ack (withdrawal). No grant results.
- Grant edge actions:
  - Capture the winner's word.
  - Set ack[winner] for exactly the next cycle.
  - Load tx_data with the tag and set tx_valid=1.
- Tag character is the hex digit of the requester index, same case rule as the digits. Colon is 8'h3A. EOL is 8'h0A.
- Digit encoding:
  - 0-9 map to 8'h30-8'h39.
  - 10-15 map to 8'h41-8'h46, or to 8'h61-8'h66 when LOWERCASE=1.
  - Digits go out in order word[31:28] first, word[3:0] last.
- Digit counter is 3 bits (0..7) and increments on each DIGITS transfer. Terminal count 7 with a transfer moves the FSM to EOL. The counter clears on grant.

## Timing
- Requester to sink latency:
  - ack and tx_valid both rise in the cycle after the grant edge.
  - First character is available 1 cycle after req is seen in IDLE.
- Handshake:
  - tx_data and tx_valid stay stable while tx_valid=1 and tx_ready=0.
  - tx_valid never drops without a transfer.
  - The next character is presented in the cycle after a transfer (registered output).
- With tx_ready held at 1, a record takes 11 consecutive cycles. IDLE then lasts at least 1 cycle, so record-to-record spacing is 12 cycles minimum.
- After the EOL transfer, tx_valid=0 and busy=0 in the next cycle.
- A new grant can occur at the edge that ends that IDLE cycle.
- Reset mid-record:
  - n_rst low asynchronously forces all outputs and the pointer to reset values.
  - The partial record is abandoned and no ack is issued.
  - Operation resumes on the first edge after n_rst is released.
- NREQ=1: the pointer is constant and the tag is always '0'.

## Structure
- Shared package dbg_pkg holds:
  - FSM state encoding: IDLE, TAG, COLON, DIGITS, EOL.
  - ASCII constants: ASCII_COLON, ASCII_LF, ASCII_ZERO, ASCII_A_UC, ASCII_A_LC.
  - Function hex2ascii(nibble, lowercase).
- One sub-module, dbg_nibble_shift:
  - 32-bit register with load and shift-by-4.
  - Outputs the current top nibble.
  - The scheduler drives shift on each DIGITS transfer.
- The round-robin priority search stays inline in the top module.

## Test plan
- req[2]=1, word 0xDEADBEEF, tx_ready=1:
  - ack=4'b0100 for 1 cycle.
  - Stream 32 3A 44 45 41 44 42 45 45 46 0A over 11 consecutive cycles.
  - busy deasserts after.
- Backpressure on word 0x01234567: tx_ready low for 3 cycles at every character.
  - tx_data is held stable during each stall.
  - The sink receives 30 3A 30 31 32 33 34 35 36 37 0A exactly once.
- req=4'b1011 held, words re-presented after each ack:
  - Grant order is 0,1,3,0,1.
  - The tags confirm the order.
- LOWERCASE=1, req[0], word 0x0000ABCD: digits are 30 30 30 30 61 62 63 64.
- n_rst pulsed low after the 5th transfer:
  - tx_valid=0 and ack=0 immediately.
  - After release with req=4'b1010, requester 1 is granted first (pointer reset) with a fresh full record.
- req[3] raised while requester 0's record is mid-stream: ack[3] is not asserted until the cycle after the IDLE grant that follows the EOL transfer.
